// File: rtl/resp_rout.sv
// resp_rout: write-response router for the B channel.
//
// Every write sent downstream is recorded in an in-order tracker FIFO. Slave
// B responses are routed back to the master side in tracker order:
//   REG   -> one master response carrying the slave bresp
//   MERGE -> one master response per merged transaction, IDs head.id+0..cnt-1,
//            all carrying the single captured slave bresp
//   BLOCK -> one locally generated OKAY response once block_fin pulses
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   trk_valid/kind/id/cnt       tracker push request; trk_ready = not full
//   s_bvalid, s_bresp, s_bready slave-side B channel
//   m_bvalid, m_bid, m_bresp,   master-side B channel (registered outputs)
//   m_bready
//   block_fin                   processor memory completion pulse for BLOCK
//   err_unexp                   registered pulse: slave response, tracker empty
//   outstanding                 tracker occupancy
module resp_rout #(
    parameter int DEPTH = 8,
    parameter int ID_W  = 4,
    parameter int CNT_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trk_valid,
    input  logic [1:0]               trk_kind,
    input  logic [ID_W-1:0]          trk_id,
    input  logic [CNT_W-1:0]         trk_cnt,
    output logic                     trk_ready,
    input  logic                     s_bvalid,
    input  logic [1:0]               s_bresp,
    output logic                     s_bready,
    output logic                     m_bvalid,
    output logic [ID_W-1:0]          m_bid,
    output logic [1:0]               m_bresp,
    input  logic                     m_bready,
    input  logic                     block_fin,
    output logic                     err_unexp,
    output logic [$clog2(DEPTH):0]   outstanding
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT_BLK, RESP} state_t;

    // Tracker storage. Entries are normalised on entry: only the BLOCK flag
    // and the effective response count are kept, so reserved kinds and a
    // zero merge count need no special handling at the head.
    logic [ID_W-1:0]  id_mem  [DEPTH];
    logic [CNT_W-1:0] cnt_mem [DEPTH];
    logic             blk_mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             m_bvalid_q, m_bvalid_d;
    logic [ID_W-1:0]  m_bid_q, m_bid_d;
    logic [1:0]       m_bresp_q, m_bresp_d;
    logic             err_q, err_d;

    logic             full, empty, push, pop;
    logic             trk_blk;
    logic [CNT_W-1:0] trk_eff;
    logic [ID_W-1:0]  head_id;
    logic [CNT_W-1:0] head_cnt;
    logic             head_blk;
    logic             s_bready_c;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push      = trk_valid & ~full;
    assign trk_blk   = (trk_kind == 2'b01);
    assign trk_eff   = ((trk_kind == 2'b10) && (trk_cnt != '0)) ? trk_cnt : CNT_W'(1);

    // Head is read asynchronously so that an entry pushed into an empty
    // tracker is visible to IDLE on the very next cycle.
    assign head_id   = id_mem[rd_ptr_q];
    assign head_cnt  = cnt_mem[rd_ptr_q];
    assign head_blk  = blk_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr_q]  <= trk_id;
            cnt_mem[wr_ptr_q] <= trk_eff;
            blk_mem[wr_ptr_q] <= trk_blk;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        m_bvalid_d = m_bvalid_q;
        m_bid_d    = m_bid_q;
        m_bresp_d  = m_bresp_q;
        err_d      = 1'b0;
        s_bready_c = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (empty) begin
                    err_d = s_bvalid;
                end else if (head_blk) begin
                    if (block_fin) begin
                        state_d    = RESP;
                        idx_d      = '0;
                        m_bvalid_d = 1'b1;
                        m_bid_d    = head_id;
                        m_bresp_d  = 2'b00;
                    end else begin
                        state_d = WAIT_BLK;
                    end
                end else begin
                    s_bready_c = 1'b1;
                    if (s_bvalid) begin
                        state_d    = RESP;
                        idx_d      = '0;
                        m_bvalid_d = 1'b1;
                        m_bid_d    = head_id;
                        m_bresp_d  = s_bresp;
                    end
                end
            end
            WAIT_BLK: begin
                if (block_fin) begin
                    state_d    = RESP;
                    idx_d      = '0;
                    m_bvalid_d = 1'b1;
                    m_bid_d    = head_id;
                    m_bresp_d  = 2'b00;
                end
            end
            RESP: begin
                if (m_bready) begin
                    if (idx_q == head_cnt - CNT_W'(1)) begin
                        pop        = 1'b1;
                        state_d    = IDLE;
                        idx_d      = '0;
                        m_bvalid_d = 1'b0;
                    end else begin
                        // IDs wrap naturally modulo 2^ID_W during fan-out.
                        idx_d   = idx_q + CNT_W'(1);
                        m_bid_d = head_id + ID_W'(idx_q) + ID_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            idx_q      <= '0;
            m_bvalid_q <= 1'b0;
            m_bid_q    <= '0;
            m_bresp_q  <= 2'b00;
            err_q      <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            m_bvalid_q <= m_bvalid_d;
            m_bid_q    <= m_bid_d;
            m_bresp_q  <= m_bresp_d;
            err_q      <= err_d;
        end
    end

    assign trk_ready   = ~full;
    assign s_bready    = s_bready_c;
    assign m_bvalid    = m_bvalid_q;
    assign m_bid       = m_bid_q;
    assign m_bresp     = m_bresp_q;
    assign err_unexp   = err_q;
    assign outstanding = count_q;
endmodule

// File: tb/tb_resp_rout.sv
module tb_resp_rout;
    localparam int DEPTH = 8;
    localparam int ID_W  = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             trk_valid = 1'b0;
    logic [1:0]       trk_kind = 2'b00;
    logic [ID_W-1:0]  trk_id = '0;
    logic [CNT_W-1:0] trk_cnt = '0;
    logic             trk_ready;
    logic             s_bvalid = 1'b0;
    logic [1:0]       s_bresp = 2'b00;
    logic             s_bready;
    logic             m_bvalid;
    logic [ID_W-1:0]  m_bid;
    logic [1:0]       m_bresp;
    logic             m_bready = 1'b0;
    logic             block_fin = 1'b0;
    logic             err_unexp;
    logic [$clog2(DEPTH):0] outstanding;

    resp_rout #(.DEPTH(DEPTH), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .trk_valid(trk_valid), .trk_kind(trk_kind), .trk_id(trk_id), .trk_cnt(trk_cnt),
        .trk_ready(trk_ready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .m_bvalid(m_bvalid), .m_bid(m_bid), .m_bresp(m_bresp), .m_bready(m_bready),
        .block_fin(block_fin), .err_unexp(err_unexp), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit verbose  = 1'b1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [ID_W-1:0] id; int cnt; bit blk; } ent_t;
    typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } rsp_t;
    ent_t trk_q[$];
    rsp_t pend_q[$];   // responses still owed for the head entry
    bit   err_exp = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_q.delete();
            pend_q.delete();
            err_exp = 1'b0;
        end else begin
            int   occ;
            bit   new_err;
            rsp_t r;
            ent_t e;
            occ     = trk_q.size();
            new_err = (occ == 0) && s_bvalid;
            if (pend_q.size() > 0) begin
                if (m_bready) begin
                    if (verbose)
                        $display("resp id=%0h bresp=%0d", pend_q[0].id, pend_q[0].resp);
                    void'(pend_q.pop_front());
                    if (pend_q.size() == 0) void'(trk_q.pop_front());
                end
            end else if (occ > 0) begin
                if (trk_q[0].blk) begin
                    if (block_fin) begin
                        r.id = trk_q[0].id; r.resp = 2'b00;
                        pend_q.push_back(r);
                    end
                end else if (s_bvalid) begin
                    for (int k = 0; k < trk_q[0].cnt; k++) begin
                        r.id   = ID_W'(trk_q[0].id + ID_W'(k));
                        r.resp = s_bresp;
                        pend_q.push_back(r);
                    end
                end
            end
            if (trk_valid && occ < DEPTH) begin
                e.id  = trk_id;
                e.blk = (trk_kind == 2'b01);
                e.cnt = (trk_kind == 2'b10 && trk_cnt != 0) ? int'(trk_cnt) : 1;
                trk_q.push_back(e);
            end
            err_exp = new_err;
        end
    end

    // Compare process: all outputs checked every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            bit exp_v, exp_sr;
            exp_v  = pend_q.size() > 0;
            exp_sr = (pend_q.size() == 0) && (trk_q.size() > 0) && !trk_q[0].blk;
            chk("m_bvalid", 32'(m_bvalid), 32'(exp_v));
            if (exp_v) begin
                chk("m_bid", 32'(m_bid), 32'(pend_q[0].id));
                chk("m_bresp", 32'(m_bresp), 32'(pend_q[0].resp));
            end
            chk("err_unexp", 32'(err_unexp), 32'(err_exp));
            chk("outstanding", 32'(outstanding), 32'(trk_q.size()));
            chk("trk_ready", 32'(trk_ready), 32'(trk_q.size() < DEPTH));
            chk("s_bready", 32'(s_bready), 32'(exp_sr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [1:0] kind, input logic [ID_W-1:0] id, input logic [CNT_W-1:0] cnt);
        trk_valid = 1'b1; trk_kind = kind; trk_id = id; trk_cnt = cnt;
    endtask

    task automatic drain();
        int n;
        n = 0;
        trk_valid = 1'b0; s_bvalid = 1'b1; m_bready = 1'b1; block_fin = 1'b1;
        while (outstanding != 0 && n < 300) begin
            tick();
            n++;
        end
        s_bvalid = 1'b0; m_bready = 1'b0; block_fin = 1'b0;
        chk("drain_done", 32'(outstanding), 32'd0);
        tick();
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_m_bvalid", 32'(m_bvalid), 32'd0);
        chk("rst_m_bid", 32'(m_bid), 32'd0);
        chk("rst_err", 32'(err_unexp), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_trk_ready", 32'(trk_ready), 32'd1);
        chk("rst_s_bready", 32'(s_bready), 32'd0);
        rst_n = 1'b1;
        tick();

        // REG id 5
        push(2'b00, 4'h5, 3'd0); tick(); trk_valid = 1'b0;
        chk("reg_out1", 32'(outstanding), 32'd1);
        s_bvalid = 1'b1; s_bresp = 2'b00; tick(); s_bvalid = 1'b0;
        chk("reg_valid", 32'(m_bvalid), 32'd1);
        chk("reg_bid", 32'(m_bid), 32'h5);
        m_bready = 1'b1; tick(); m_bready = 1'b0;
        chk("reg_out0", 32'(outstanding), 32'd0);

        // MERGE id 2 cnt 3, bresp 10
        push(2'b10, 4'h2, 3'd3); tick(); trk_valid = 1'b0;
        s_bvalid = 1'b1; s_bresp = 2'b10; tick(); s_bvalid = 1'b0;
        chk("mrg_bid0", 32'(m_bid), 32'h2);
        chk("mrg_sready", 32'(s_bready), 32'd0);
        m_bready = 1'b1; tick();
        chk("mrg_bid1", 32'(m_bid), 32'h3);
        tick();
        chk("mrg_bid2", 32'(m_bid), 32'h4);
        chk("mrg_bresp2", 32'(m_bresp), 32'h2);
        tick(); m_bready = 1'b0;
        chk("mrg_done", 32'(m_bvalid), 32'd0);

        // BLOCK id 7 then REG id 1
        push(2'b01, 4'h7, 3'd0); tick();
        push(2'b00, 4'h1, 3'd0); tick(); trk_valid = 1'b0;
        s_bvalid = 1'b1; s_bresp = 2'b01;
        repeat (3) begin
            tick();
            chk("blk_stall", 32'(s_bready), 32'd0);
        end
        block_fin = 1'b1; tick(); block_fin = 1'b0;
        chk("blk_bid", 32'(m_bid), 32'h7);
        chk("blk_bresp", 32'(m_bresp), 32'h0);
        m_bready = 1'b1; tick(); m_bready = 1'b0;
        chk("blk_bubble", 32'(m_bvalid), 32'd0);
        chk("blk_next_sready", 32'(s_bready), 32'd1);
        tick(); s_bvalid = 1'b0;
        chk("blk_reg_bid", 32'(m_bid), 32'h1);
        chk("blk_reg_bresp", 32'(m_bresp), 32'h1);
        m_bready = 1'b1; tick(); m_bready = 1'b0;

        // Fill to full
        for (int i = 0; i < DEPTH; i++) begin
            push(2'b00, 4'(i), 3'd0); tick();
        end
        chk("full_out", 32'(outstanding), 32'd8);
        chk("full_ready", 32'(trk_ready), 32'd0);
        push(2'b00, 4'h9, 3'd0); tick(); trk_valid = 1'b0;
        chk("full_ignored", 32'(outstanding), 32'd8);
        s_bvalid = 1'b1; tick(); s_bvalid = 1'b0;
        m_bready = 1'b1; tick(); m_bready = 1'b0;
        chk("pop_ready", 32'(trk_ready), 32'd1);
        chk("pop_out", 32'(outstanding), 32'd7);
        s_bvalid = 1'b1; tick(); s_bvalid = 1'b0;
        m_bready = 1'b1; push(2'b00, 4'h3, 3'd0); tick();
        m_bready = 1'b0; trk_valid = 1'b0;
        chk("pushpop_out", 32'(outstanding), 32'd7);
        drain();

        // Unexpected response on empty tracker
        s_bvalid = 1'b1; s_bresp = 2'b11; tick();
        chk("unexp1", 32'(err_unexp), 32'd1);
        tick();
        chk("unexp2", 32'(err_unexp), 32'd1);
        chk("unexp_sready", 32'(s_bready), 32'd0);
        push(2'b00, 4'hA, 3'd0); tick(); trk_valid = 1'b0;
        chk("unexp_sready_on", 32'(s_bready), 32'd1);
        tick(); s_bvalid = 1'b0;
        chk("unexp_clear", 32'(err_unexp), 32'd0);
        chk("unexp_bid", 32'(m_bid), 32'hA);
        chk("unexp_bresp", 32'(m_bresp), 32'h3);
        m_bready = 1'b1; tick(); m_bready = 1'b0;

        // Reset mid-fan-out, with ID wrap F -> 0
        push(2'b10, 4'hF, 3'd3); tick(); trk_valid = 1'b0;
        s_bvalid = 1'b1; s_bresp = 2'b01; tick(); s_bvalid = 1'b0;
        chk("wrap_bid0", 32'(m_bid), 32'hF);
        m_bready = 1'b1; tick(); m_bready = 1'b0;
        chk("wrap_bid1", 32'(m_bid), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bvalid", 32'(m_bvalid), 32'd0);
        chk("arst_out", 32'(outstanding), 32'd0);
        tick(); rst_n = 1'b1;
        push(2'b00, 4'h6, 3'd0); tick(); trk_valid = 1'b0;
        s_bvalid = 1'b1; s_bresp = 2'b00; tick(); s_bvalid = 1'b0;
        chk("post_rst_bid", 32'(m_bid), 32'h6);
        m_bready = 1'b1; tick(); m_bready = 1'b0;

        // Randomized traffic against the model
        verbose = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            trk_valid = ($urandom_range(0, 3) == 0);
            trk_kind  = 2'($urandom);
            trk_id    = ID_W'($urandom);
            trk_cnt   = CNT_W'($urandom);
            s_bvalid  = ($urandom_range(0, 2) != 0);
            s_bresp   = 2'($urandom);
            m_bready  = ($urandom_range(0, 3) != 0);
            block_fin = ($urandom_range(0, 5) == 0);
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
